if_id_stall_reg: RTL

IF/ID pipeline register and stall/flush sequencer for the 5-stage pipeline. It receives the stall request from the hazard (stall) controller and the branch-taken flush from MEM. It holds or advances the fetched instruction, gates the PC write, and tells the ID/EX register when to capture a bubble. It also keeps saturating stall/flush statistics and a consecutive-stall watchdog that flags pipeline deadlock.

---
 rtl/if_id_stall_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/if_id_stall_reg.sv
// IF/ID pipeline register with stall/flush sequencing, saturating stall/flush
// statistics and a sticky consecutive-stall watchdog.
module if_id_stall_reg #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int WD_LIMIT = 8
) (
  input  logic              ip_clk,
  input  logic              ip_reset,
  input  logic [DATA_W-1:0] ip_instruction_IF,
  input  logic [DATA_W-1:0] ip_pc_plus4_IF,
  input  logic              ip_valid_IF,
  input  logic              ip_stall,
  input  logic              ip_flush,
  output logic [DATA_W-1:0] op_instruction_ID,
  output logic [DATA_W-1:0] op_pc_plus4_ID,
  output logic              op_valid_ID,
  output logic              op_pc_write,
  output logic              op_bubble_EX,
  output logic [CNT_W-1:0]  op_stall_count,
  output logic [CNT_W-1:0]  op_flush_count,
  output logic              op_stall_timeout,
  output logic              op_fsm_state
);

  localparam int RL_W = $clog2(WD_LIMIT + 1);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(WD_LIMIT);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [RL_W-1:0]   run_len_q, run_len_d;
  logic              timeout_q, timeout_d;

  // Flush wins over stall: the branch in MEM is older than the load-use pair.
  assign op_pc_write  = ip_flush | ~ip_stall;
  assign op_bubble_EX = ip_flush | ip_stall;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_len_d   = run_len_q;
    timeout_d   = timeout_q;

    if (ip_flush) begin
      instr_d     = '0;
      pc4_d       = '0;
      valid_d     = 1'b0;
      flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + 1'b1;
      run_len_d   = '0;
      state_d     = RUN;
    end else if (ip_stall) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
      run_len_d   = (run_len_q == RL_MAX) ? run_len_q : run_len_q + 1'b1;
      state_d     = HOLD;
      // Trips on the edge the consecutive-stall run reaches the limit.
      if (run_len_d == RL_MAX) timeout_d = 1'b1;
    end else begin
      instr_d   = ip_instruction_IF;
      pc4_d     = ip_pc_plus4_IF;
      valid_d   = ip_valid_IF;
      run_len_d = '0;
      state_d   = RUN;
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_reset) begin
      state_q     <= RUN;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_len_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_len_q   <= run_len_d;
      timeout_q   <= timeout_d;
    end
  end

  assign op_instruction_ID = instr_q;
  assign op_pc_plus4_ID    = pc4_q;
  assign op_valid_ID       = valid_q;
  assign op_stall_count    = stall_cnt_q;
  assign op_flush_count    = flush_cnt_q;
  assign op_stall_timeout  = timeout_q;
  assign op_fsm_state      = state_q;

endmodule
